// File: rtl/centroid_pkg.sv
// Shared defaults and FSM encoding for the centroid moments stage.
// Width defaults match a 1280x720 frame; override per instance for other geometries.
package centroid_pkg;

    localparam int DEF_IMG_W = 1280;
    localparam int DEF_IMG_H = 720;
    localparam int DEF_XW    = 11;
    localparam int DEF_YW    = 10;
    localparam int DEF_M00W  = 20;
    localparam int DEF_M10W  = 31;
    localparam int DEF_M01W  = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2
    } state_t;

endpackage

// File: rtl/centroid_edge_det.sv
// Registered edge detector: pulse is high while sig differs from last cycle's value in the chosen direction.
// Latency: combinational pulse off the live input, one register of history.
// Backpressure: none, free-running.
module centroid_edge_det #(
    parameter bit RISING = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic pulse
);

    logic dly_q, dly_d;

    always_comb begin
        dly_d = sig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q <= 1'b0;
        end else begin
            dly_q <= dly_d;
        end
    end

    assign pulse = RISING ? (sig & ~dly_q) : (dly_q & ~sig);

endmodule

// File: rtl/centroid_moments.sv
// Per-frame image moments (m00, m10, m01) of a binarised pixel stream; optional bbox under CENTROID_BBOX_EN.
// Latency: frame_valid rises 2 cycles after the vsync rising edge reaches the input.
// Backpressure: none; streaming input, results held until the next frame_valid.
module centroid_moments
    import centroid_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int XW    = DEF_XW,
    parameter int YW    = DEF_YW,
    parameter int M00W  = DEF_M00W,
    parameter int M10W  = DEF_M10W,
    parameter int M01W  = DEF_M01W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            de,
    input  logic            vsync,
    input  logic            mask,
    output logic [M00W-1:0] m00,
    output logic [M10W-1:0] m10,
    output logic [M01W-1:0] m01,
    output logic            frame_valid,
    output logic            geom_err
`ifdef CENTROID_BBOX_EN
    ,
    output logic [XW-1:0]   bb_xmin,
    output logic [XW-1:0]   bb_xmax,
    output logic [YW-1:0]   bb_ymin,
    output logic [YW-1:0]   bb_ymax
`endif
);

    // x needs one extra bit so it can sit at IMG_W when a line runs long.
    localparam logic [XW:0]   X_END  = (XW+1)'(IMG_W);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    state_t          state_q, state_d;
    logic            vs_rise, line_end;
    logic            pix_take, publish, clr;
    logic [XW:0]     x_q, x_d;
    logic [XW-1:0]   x_lo;
    logic [YW-1:0]   y_q, y_d;
    logic            y_full_q, y_full_d;
    logic            err_q, err_d;
    logic [M00W-1:0] m00_acc_q, m00_acc_d, m00_q, m00_d;
    logic [M10W-1:0] m10_acc_q, m10_acc_d, m10_q, m10_d;
    logic [M01W-1:0] m01_acc_q, m01_acc_d, m01_q, m01_d;
    logic            fv_q, fv_d;
    logic            gerr_q, gerr_d;
`ifdef CENTROID_BBOX_EN
    logic [XW-1:0]   xmin_acc_q, xmin_acc_d, xmax_acc_q, xmax_acc_d;
    logic [YW-1:0]   ymin_acc_q, ymin_acc_d, ymax_acc_q, ymax_acc_d;
    logic [XW-1:0]   bb_xmin_q, bb_xmin_d, bb_xmax_q, bb_xmax_d;
    logic [YW-1:0]   bb_ymin_q, bb_ymin_d, bb_ymax_q, bb_ymax_d;
`endif

    centroid_edge_det #(.RISING(1'b1)) u_vs_det (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (vsync),
        .pulse (vs_rise)
    );

    centroid_edge_det #(.RISING(1'b0)) u_de_det (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (de),
        .pulse (line_end)
    );

    assign x_lo = x_q[XW-1:0];

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        y_full_d  = y_full_q;
        err_d     = err_q;
        m00_acc_d = m00_acc_q;
        m10_acc_d = m10_acc_q;
        m01_acc_d = m01_acc_q;
        m00_d     = m00_q;
        m10_d     = m10_q;
        m01_d     = m01_q;
        gerr_d    = gerr_q;
        fv_d      = 1'b0;
        pix_take  = 1'b0;
        publish   = 1'b0;
        clr       = 1'b0;
`ifdef CENTROID_BBOX_EN
        xmin_acc_d = xmin_acc_q;
        xmax_acc_d = xmax_acc_q;
        ymin_acc_d = ymin_acc_q;
        ymax_acc_d = ymax_acc_q;
        bb_xmin_d  = bb_xmin_q;
        bb_xmax_d  = bb_xmax_q;
        bb_ymin_d  = bb_ymin_q;
        bb_ymax_d  = bb_ymax_q;
`endif

        case (state_q)
            IDLE: begin
                if (vs_rise) begin
                    clr     = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_d = FLUSH;
                end
                if (de) begin
                    // y stays clamped on the last line; a pixel arriving after that line closed is the error.
                    if (y_full_q) begin
                        err_d = 1'b1;
                    end
                    if (x_q == X_END) begin
                        err_d = 1'b1;
                    end else begin
                        pix_take = mask;
                        x_d      = x_q + (XW+1)'(1);
                    end
                end
                if (line_end) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_full_d = 1'b1;
                    end else begin
                        y_d = y_q + YW'(1);
                    end
                end
            end
            FLUSH: begin
                publish = 1'b1;
                clr     = 1'b1;
                state_d = ACTIVE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pix_take) begin
            m00_acc_d = m00_acc_q + M00W'(1);
            m10_acc_d = m10_acc_q + M10W'(x_lo);
            m01_acc_d = m01_acc_q + M01W'(y_q);
`ifdef CENTROID_BBOX_EN
            if (x_lo < xmin_acc_q) xmin_acc_d = x_lo;
            if (x_lo > xmax_acc_q) xmax_acc_d = x_lo;
            if (y_q < ymin_acc_q)  ymin_acc_d = y_q;
            if (y_q > ymax_acc_q)  ymax_acc_d = y_q;
`endif
        end

        if (publish) begin
            m00_d  = m00_acc_q;
            m10_d  = m10_acc_q;
            m01_d  = m01_acc_q;
            gerr_d = err_q;
            fv_d   = 1'b1;
`ifdef CENTROID_BBOX_EN
            bb_xmin_d = xmin_acc_q;
            bb_xmax_d = xmax_acc_q;
            bb_ymin_d = ymin_acc_q;
            bb_ymax_d = ymax_acc_q;
`endif
        end

        if (clr) begin
            x_d       = '0;
            y_d       = '0;
            y_full_d  = 1'b0;
            err_d     = 1'b0;
            m00_acc_d = '0;
            m10_acc_d = '0;
            m01_acc_d = '0;
`ifdef CENTROID_BBOX_EN
            xmin_acc_d = '1;
            xmax_acc_d = '0;
            ymin_acc_d = '1;
            ymax_acc_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            y_full_q  <= 1'b0;
            err_q     <= 1'b0;
            m00_acc_q <= '0;
            m10_acc_q <= '0;
            m01_acc_q <= '0;
            m00_q     <= '0;
            m10_q     <= '0;
            m01_q     <= '0;
            fv_q      <= 1'b0;
            gerr_q    <= 1'b0;
`ifdef CENTROID_BBOX_EN
            xmin_acc_q <= '1;
            xmax_acc_q <= '0;
            ymin_acc_q <= '1;
            ymax_acc_q <= '0;
            bb_xmin_q  <= '1;
            bb_xmax_q  <= '0;
            bb_ymin_q  <= '1;
            bb_ymax_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            y_full_q  <= y_full_d;
            err_q     <= err_d;
            m00_acc_q <= m00_acc_d;
            m10_acc_q <= m10_acc_d;
            m01_acc_q <= m01_acc_d;
            m00_q     <= m00_d;
            m10_q     <= m10_d;
            m01_q     <= m01_d;
            fv_q      <= fv_d;
            gerr_q    <= gerr_d;
`ifdef CENTROID_BBOX_EN
            xmin_acc_q <= xmin_acc_d;
            xmax_acc_q <= xmax_acc_d;
            ymin_acc_q <= ymin_acc_d;
            ymax_acc_q <= ymax_acc_d;
            bb_xmin_q  <= bb_xmin_d;
            bb_xmax_q  <= bb_xmax_d;
            bb_ymin_q  <= bb_ymin_d;
            bb_ymax_q  <= bb_ymax_d;
`endif
        end
    end

    assign m00         = m00_q;
    assign m10         = m10_q;
    assign m01         = m01_q;
    assign frame_valid = fv_q;
    assign geom_err    = gerr_q;
`ifdef CENTROID_BBOX_EN
    assign bb_xmin = bb_xmin_q;
    assign bb_xmax = bb_xmax_q;
    assign bb_ymin = bb_ymin_q;
    assign bb_ymax = bb_ymax_q;
`endif

endmodule

// File: tb/tb_centroid_moments.sv
// Directed bench for centroid_moments on a 4x4 geometry; bbox checks compile in with CENTROID_BBOX_EN.
module tb_centroid_moments;

    localparam int IMG_W = 4;
    localparam int IMG_H = 4;
    localparam int XW    = 2;
    localparam int YW    = 2;
    localparam int M00W  = 5;
    localparam int M10W  = 6;
    localparam int M01W  = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            de;
    logic            vsync;
    logic            mask;
    logic [M00W-1:0] m00;
    logic [M10W-1:0] m10;
    logic [M01W-1:0] m01;
    logic            frame_valid;
    logic            geom_err;
`ifdef CENTROID_BBOX_EN
    logic [XW-1:0]   bb_xmin, bb_xmax;
    logic [YW-1:0]   bb_ymin, bb_ymax;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Last published values the bench expects the outputs to hold.
    int h00 = 0;
    int h10 = 0;
    int h01 = 0;
    int hg  = 0;

    centroid_moments #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .XW    (XW),
        .YW    (YW),
        .M00W  (M00W),
        .M10W  (M10W),
        .M01W  (M01W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .de          (de),
        .vsync       (vsync),
        .mask        (mask),
        .m00         (m00),
        .m10         (m10),
        .m01         (m01),
        .frame_valid (frame_valid),
        .geom_err    (geom_err)
`ifdef CENTROID_BBOX_EN
        ,
        .bb_xmin     (bb_xmin),
        .bb_xmax     (bb_xmax),
        .bb_ymin     (bb_ymin),
        .bb_ymax     (bb_ymax)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1, "watchdog");
    end

    // Drive one line of n de cycles (mask from bits), then a 2-cycle blanking gap; outputs must hold.
    task automatic send_line(input logic [7:0] bits, input int n, input string tag);
        for (int i = 0; i < n + 2; i++) begin
            de   = (i < n);
            mask = (i < n) ? bits[i] : 1'b0;
            @(negedge clk);
            vectors++;
            if (frame_valid !== 1'b0 || m00 !== h00 || m10 !== h10 || m01 !== h01 || geom_err !== hg) begin
                miscompares++;
                $display("FAIL %s hold: got fv=%0b m00=%0d m10=%0d m01=%0d gerr=%0b, want fv=0 m00=%0d m10=%0d m01=%0d gerr=%0d",
                         tag, frame_valid, m00, m10, m01, geom_err, h00, h10, h01, hg);
            end
        end
    endtask

    task automatic send_frame(input logic [15:0] mk, input string tag);
        for (int r = 0; r < IMG_H; r++) begin
            send_line({4'b0000, mk[r*4 +: 4]}, IMG_W, tag);
        end
    endtask

    // vsync rise from IDLE: the FSM arms but must not publish.
    task automatic vsync_idle(input string tag);
        vsync = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (frame_valid !== 1'b0 || m00 !== h00 || m10 !== h10 || m01 !== h01) begin
                miscompares++;
                $display("FAIL %s idle_vsync: got fv=%0b m00=%0d m10=%0d m01=%0d, want fv=0 m00=%0d m10=%0d m01=%0d",
                         tag, frame_valid, m00, m10, m01, h00, h10, h01);
            end
        end
        vsync = 1'b0;
        @(negedge clk);
    endtask

    // vsync rise that closes a frame: pulse must appear exactly on the second sampled cycle.
    task automatic end_frame(input string tag, input int e00, input int e10, input int e01, input int eg,
                             input int bx0, input int bx1, input int by0, input int by1);
        vsync = 1'b1;
        @(negedge clk);
        vectors++;
        if (frame_valid !== 1'b0 || m00 !== h00) begin
            miscompares++;
            $display("FAIL %s early: got fv=%0b m00=%0d, want fv=0 m00=%0d", tag, frame_valid, m00, h00);
        end
        @(negedge clk);
        vectors++;
        if (frame_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s fv_pulse: got %0b, want 1", tag, frame_valid);
        end
        vectors++;
        if (m00 !== e00) begin
            miscompares++;
            $display("FAIL %s m00: got %0d, want %0d", tag, m00, e00);
        end
        vectors++;
        if (m10 !== e10) begin
            miscompares++;
            $display("FAIL %s m10: got %0d, want %0d", tag, m10, e10);
        end
        vectors++;
        if (m01 !== e01) begin
            miscompares++;
            $display("FAIL %s m01: got %0d, want %0d", tag, m01, e01);
        end
        vectors++;
        if (geom_err !== eg) begin
            miscompares++;
            $display("FAIL %s geom_err: got %0b, want %0d", tag, geom_err, eg);
        end
`ifdef CENTROID_BBOX_EN
        vectors++;
        if (bb_xmin !== bx0 || bb_xmax !== bx1 || bb_ymin !== by0 || bb_ymax !== by1) begin
            miscompares++;
            $display("FAIL %s bbox: got x %0d..%0d y %0d..%0d, want x %0d..%0d y %0d..%0d",
                     tag, bb_xmin, bb_xmax, bb_ymin, bb_ymax, bx0, bx1, by0, by1);
        end
`endif
        h00 = e00;
        h10 = e10;
        h01 = e01;
        hg  = eg;
        vsync = 1'b0;
        @(negedge clk);
        vectors++;
        if (frame_valid !== 1'b0 || m00 !== h00 || m10 !== h10 || m01 !== h01 || geom_err !== hg) begin
            miscompares++;
            $display("FAIL %s fv_width: got fv=%0b m00=%0d m10=%0d m01=%0d gerr=%0b, want fv=0 m00=%0d m10=%0d m01=%0d gerr=%0d",
                     tag, frame_valid, m00, m10, m01, geom_err, h00, h10, h01, hg);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        de    = 1'b0;
        vsync = 1'b0;
        mask  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (m00 !== 0 || m10 !== 0 || m01 !== 0) begin
            miscompares++;
            $display("FAIL reset_sums: got m00=%0d m10=%0d m01=%0d, want 0 0 0", m00, m10, m01);
        end
        vectors++;
        if (frame_valid !== 1'b0 || geom_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got fv=%0b gerr=%0b, want 0 0", frame_valid, geom_err);
        end
`ifdef CENTROID_BBOX_EN
        vectors++;
        if (bb_xmin !== 2'd3 || bb_xmax !== 2'd0 || bb_ymin !== 2'd3 || bb_ymax !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_bbox: got x %0d..%0d y %0d..%0d, want x 3..0 y 3..0", bb_xmin, bb_xmax, bb_ymin, bb_ymax);
        end
`endif
        // Build up a partial frame, then reset in the middle of a line.
        vsync_idle("pre_reset");
        send_line(8'h0F, 4, "pre_reset");
        de   = 1'b1;
        mask = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        de    = 1'b0;
        mask  = 1'b0;
        @(negedge clk);
        vectors++;
        if (m00 !== 0 || frame_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_line: got m00=%0d fv=%0b, want 0 0", m00, frame_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (m00 !== 0 || m10 !== 0 || m01 !== 0 || frame_valid !== 1'b0 || geom_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: got m00=%0d m10=%0d m01=%0d fv=%0b gerr=%0b, want all 0",
                     m00, m10, m01, frame_valid, geom_err);
        end
        h00 = 0; h10 = 0; h01 = 0; hg = 0;
        // First vsync after reset only opens a frame.
        vsync_idle("post_reset");
    endtask

    task automatic test_single_pixel();
        send_frame(16'h0040, "single");
        end_frame("single", 1, 2, 1, 0, 2, 2, 1, 1);
    endtask

    task automatic test_full_frame();
        send_frame(16'hFFFF, "full");
        end_frame("full", 16, 24, 24, 0, 0, 3, 0, 3);
    endtask

    task automatic test_empty_frame();
        send_frame(16'h0000, "empty");
        end_frame("empty", 0, 0, 0, 0, 3, 0, 3, 0);
    endtask

    task automatic test_overrun();
        send_line(8'h3F, 6, "overrun");
        send_line(8'h00, 4, "overrun");
        send_line(8'h00, 4, "overrun");
        send_line(8'h00, 4, "overrun");
        end_frame("overrun", 4, 6, 0, 1, 0, 3, 0, 0);
        // Clean frame right after: error must clear.
        send_frame(16'h2000, "after_overrun");
        end_frame("after_overrun", 1, 1, 3, 0, 1, 1, 3, 3);
    endtask

    task automatic test_back_to_back();
        send_frame(16'h0A00, "b2b_a");
        end_frame("b2b_a", 2, 4, 4, 0, 1, 3, 2, 2);
        send_frame(16'h0001, "b2b_b");
        end_frame("b2b_b", 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_full_frame();
        test_empty_frame();
        test_overrun();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
